// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter. A packed DIGITS-digit BCD word is
//   captured on start and folded MSD-first, one digit per clock, with
//   acc = acc*10 + digit. Digits above 9 flag error for that conversion.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     start    in   conversion request, honoured only in IDLE or DONE
//     bcd_in   in   [4*DIGITS-1:0] BCD word, MSD in top nibble, sampled with start
//     busy     out  high while digits are being processed
//     done     out  one-cycle pulse when bin_out/error are fresh
//     bin_out  out  [OUT_W-1:0] result, held until the next conversion ends
//     error    out  some digit of the last conversion was > 9
//
//   Build option
//     BCD2BIN_ABORT_EN  when defined, the first invalid digit terminates the
//                       conversion immediately with bin_out=0, error=1.
//                       When undefined, invalid digits count as 0 and the
//                       partial value is reported alongside error=1.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  error
);

    localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EXT_W = OUT_W + 4;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t                state, nxt;
    logic [4*DIGITS-1:0]   shreg;
    logic [OUT_W-1:0]      acc;
    logic [CW-1:0]         cnt;
    logic                  err_int;

    logic [3:0]            dig;
    logic                  inv;
    logic [3:0]            dv;
    logic [OUT_W-1:0]      acc_nx;
    logic                  accept;
    logic                  fin;

    // Current digit is always the top nibble; the register shifts left.
    assign dig = shreg[4*DIGITS-1 -: 4];
    assign inv = (dig > 4'd9);
    assign dv  = inv ? 4'd0 : dig;

    // Widened by 4 bits so the *10 cannot wrap before the final truncation.
    assign acc_nx = OUT_W'(({4'b0000, acc} * EXT_W'(10)) + EXT_W'(dv));

`ifdef BCD2BIN_ABORT_EN
    assign fin = (state == S_CONV) && ((cnt == '0) || inv);
`else
    assign fin = (state == S_CONV) && (cnt == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = S_CONV;
                end
            end
            S_CONV: begin
                busy = 1'b1;
                if (fin) nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back start skips the idle bubble.
                if (start) begin
                    accept = 1'b1;
                    nxt    = S_CONV;
                end else begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_int <= 1'b0;
            bin_out <= '0;
            error   <= 1'b0;
        end else if (accept) begin
            shreg   <= bcd_in;
            acc     <= '0;
            err_int <= 1'b0;
            cnt     <= CW'(DIGITS - 1);
        end else if (state == S_CONV) begin
            acc     <= acc_nx;
            shreg   <= shreg << 4;
            cnt     <= cnt - CW'(1);
            err_int <= err_int | inv;
            // Results only move here, so they stay stable through the next CONV.
            if (fin) begin
`ifdef BCD2BIN_ABORT_EN
                if (inv) begin
                    bin_out <= '0;
                    error   <= 1'b1;
                end else begin
                    bin_out <= acc_nx;
                    error   <= err_int;
                end
`else
                bin_out <= acc_nx;
                error   <= err_int | inv;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       busy, done, error;
    logic [6:0] bin_out;

    typedef struct packed {
        logic [6:0] bin;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         nvec = 0;
    int         nerr = 0;
    logic [6:0] last_bin = 7'd0;
    logic       last_err = 1'b0;

    bcd_to_bin_seq #(.DIGITS(2), .OUT_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .error(error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) begin
                nvec++; nerr++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
            end
            if (done) begin
                exp_t e;
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_done: bin_out=%0d with no pending conversion", bin_out);
                end else begin
                    e = sb.pop_front();
                    if (bin_out !== e.bin || error !== e.err) begin
                        nerr++;
                        $display("FAIL result: bin_out=%0d error=%0b, required bin_out=%0d error=%0b",
                                 bin_out, error, e.bin, e.err);
                    end
                    last_bin = e.bin;
                    last_err = e.err;
                end
            end
        end
    end

    // One conversion from idle; checks busy length and result holding.
    task automatic run_conv(input logic [7:0] bcd, input logic [6:0] eb,
                            input logic ee, input int ebusy);
        int nb = 0;
        int n  = 0;
        @(negedge clk);
        start = 1'b1; bcd_in = bcd;
        sb.push_back('{bin: eb, err: ee});
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (bin_out !== last_bin || error !== last_err) begin
            nerr++;
            $display("FAIL hold_during_conv: bin_out=%0d error=%0b, required %0d %0b",
                     bin_out, error, last_bin, last_err);
        end
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        nvec++;
        if (n >= 20) begin
            nerr++;
            $display("FAIL timeout_%h: no done within 20 cycles", bcd);
        end else if (nb != ebusy) begin
            nerr++;
            $display("FAIL busy_len_%h: busy cycles=%0d, required %0d", bcd, nb, ebusy);
        end
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 7'd0 || error !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: busy=%0b done=%0b bin_out=%0d error=%0b, required all 0",
                     busy, done, bin_out, error);
        end
        @(negedge clk); rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            nvec++;
            if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 7'd0 || error !== 1'b0) begin
                nerr++;
                $display("FAIL idle_state: busy=%0b done=%0b bin_out=%0d error=%0b, required all 0",
                         busy, done, bin_out, error);
            end
        end
    endtask

    task automatic test_basic();
        run_conv(8'h42, 7'd42, 1'b0, 2);
        run_conv(8'h99, 7'd99, 1'b0, 2);
        run_conv(8'h00, 7'd0,  1'b0, 2);
        for (int i = 0; i < 6; i++) begin
            int v = $urandom_range(0, 99);
            logic [3:0] t = 4'(v / 10);
            logic [3:0] o = 4'(v % 10);
            run_conv({t, o}, 7'(v), 1'b0, 2);
        end
    endtask

    task automatic test_invalid();
`ifdef BCD2BIN_ABORT_EN
        run_conv(8'hB4, 7'd0, 1'b1, 1);
`else
        run_conv(8'hB4, 7'd4, 1'b1, 2);
        run_conv(8'h3F, 7'd30, 1'b1, 2);
`endif
        run_conv(8'h07, 7'd7, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int gap = 0;
        @(negedge clk);
        start = 1'b1; bcd_in = 8'h12;
        sb.push_back('{bin: 7'd12, err: 1'b0});
        @(negedge clk);
        while (!done && n < 20) begin @(negedge clk); n++; end
        bcd_in = 8'h34;
        sb.push_back('{bin: 7'd34, err: 1'b0});
        @(negedge clk);
        gap = 1;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        start = 1'b0;
        nvec++;
        if (gap != 3) begin
            nerr++;
            $display("FAIL b2b_period: done spacing=%0d cycles, required 3", gap);
        end
    endtask

    task automatic test_ignore();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; bcd_in = 8'h57;
        sb.push_back('{bin: 7'd57, err: 1'b0});
        @(negedge clk);
        bcd_in = 8'h11;          // still start=1, now mid-CONV
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            if (done) ndone++;
            @(negedge clk);
        end
        nvec++;
        if (ndone != 1) begin
            nerr++;
            $display("FAIL ignore_start: done pulses=%0d, required 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; bcd_in = 8'h88;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 7'd0 || error !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid: busy=%0b done=%0b bin_out=%0d error=%0b, required all 0",
                     busy, done, bin_out, error);
        end
        last_bin = 7'd0; last_err = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        nvec++;
        if (ndone != 0) begin
            nerr++;
            $display("FAIL reset_mid_done: done pulses=%0d, required 0", ndone);
        end
        run_conv(8'h05, 7'd5, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        repeat (3) @(negedge clk);
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
